// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register sequencer: engine command encodings,
// step indices, FSM states and the per-step command/data decode.
package i2c_pkg;

   localparam int unsigned CMD_W  = 6;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned STEP_W = 3;
   localparam int unsigned DEV_W  = 7;
   localparam int unsigned ADDR_W = 16;

   localparam logic [CMD_W-1:0] CMD_WR   = 6'b000001;
   localparam logic [CMD_W-1:0] CMD_STA  = 6'b000010;
   localparam logic [CMD_W-1:0] CMD_RD   = 6'b000100;
   localparam logic [CMD_W-1:0] CMD_STO  = 6'b001000;
   localparam logic [CMD_W-1:0] CMD_ACK  = 6'b010000;
   localparam logic [CMD_W-1:0] CMD_NACK = 6'b100000;

   // Step 3 is the data byte of a write or the repeated-start device byte of a read.
   localparam logic [STEP_W-1:0] STEP_DEV  = 3'd0;
   localparam logic [STEP_W-1:0] STEP_AHI  = 3'd1;
   localparam logic [STEP_W-1:0] STEP_ALO  = 3'd2;
   localparam logic [STEP_W-1:0] STEP_DATA = 3'd3;
   localparam logic [STEP_W-1:0] STEP_RD   = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [BYTE_W-1:0] tx;
   } step_t;

   function automatic step_t step_decode(input logic              is_rd,
                                         input logic [DEV_W-1:0]  dev,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [BYTE_W-1:0] data,
                                         input logic [STEP_W-1:0] step);
      step_t s;
      s.cmd = '0;
      s.tx  = '0;
      case (step)
         STEP_DEV: begin
            s.cmd = CMD_STA | CMD_WR;
            s.tx  = {dev, 1'b0};
         end
         STEP_AHI: begin
            s.cmd = CMD_WR;
            s.tx  = addr[15:8];
         end
         STEP_ALO: begin
            s.cmd = is_rd ? (CMD_WR | CMD_STO) : CMD_WR;
            s.tx  = addr[7:0];
         end
         STEP_DATA: begin
            s.cmd = is_rd ? (CMD_STA | CMD_WR) : (CMD_WR | CMD_STO);
            s.tx  = is_rd ? {dev, 1'b1} : data;
         end
         STEP_RD: begin
            s.cmd = CMD_RD | CMD_NACK | CMD_STO;
            s.tx  = '0;
         end
         default: begin
            s.cmd = '0;
            s.tx  = '0;
         end
      endcase
      return s;
   endfunction

   function automatic logic [STEP_W-1:0] last_step(input logic is_rd);
      return is_rd ? STEP_RD : STEP_DATA;
   endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Register write/read sequencer: expands one request into the byte engine's
// Cmd/Go step sequence and reports completion, read data and a sticky ACK error.
module i2c_reg_ctrl
   import i2c_pkg::*;
#(
   parameter bit ACK_CHECK_EN = 1'b1
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                wrreg_req,
   input  logic                rdreg_req,
   input  logic [DEV_W-1:0]    dev_id,
   input  logic                addr_mode,
   input  logic [ADDR_W-1:0]   reg_addr,
   input  logic [BYTE_W-1:0]   wr_data,
   output logic [BYTE_W-1:0]   rd_data,
   output logic                RW_Done,
   output logic                ack_err,
   output logic                busy,
   output logic [CMD_W-1:0]    Cmd,
   output logic                Go,
   output logic [BYTE_W-1:0]   Tx_DATA,
   input  logic [BYTE_W-1:0]   Rx_DATA,
   input  logic                Trans_Done,
   input  logic                ack_o
);

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                op_rd_q, op_rd_d;
   logic [DEV_W-1:0]    dev_q, dev_d;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BYTE_W-1:0]   data_q, data_d;
   logic                err_q, err_d;

   logic [CMD_W-1:0]    cmd_d;
   logic                go_d;
   logic [BYTE_W-1:0]   tx_d;
   logic [BYTE_W-1:0]   rd_data_d;
   logic                rw_done_d;
   logic                ack_err_d;
   logic                busy_d;

   logic [STEP_W-1:0]   step_adv;
   step_t               dec;

   // Next-state and next-output logic; every output is registered so Go is
   // high exactly while the FSM sits in ISSUE.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      op_rd_d   = op_rd_q;
      dev_d     = dev_q;
      mode_d    = mode_q;
      addr_d    = addr_q;
      data_d    = data_q;
      err_d     = err_q;
      cmd_d     = Cmd;
      go_d      = 1'b0;
      tx_d      = Tx_DATA;
      rd_data_d = rd_data;
      rw_done_d = 1'b0;
      ack_err_d = 1'b0;
      busy_d    = busy;
      step_adv  = '0;
      dec       = '0;

      case (state_q)
         ST_IDLE: begin
            if (wrreg_req || rdreg_req) begin
               op_rd_d = !wrreg_req;
               dev_d   = dev_id;
               mode_d  = addr_mode;
               addr_d  = reg_addr;
               data_d  = wr_data;
               err_d   = 1'b0;
               step_d  = STEP_DEV;
               dec     = step_decode(!wrreg_req, dev_id, reg_addr, wr_data, STEP_DEV);
               cmd_d   = dec.cmd;
               tx_d    = dec.tx;
               go_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (Trans_Done) begin
               if ((ACK_CHECK_EN == 1'b1) && ((Cmd & CMD_WR) != '0)) begin
                  err_d = err_q | ack_o;
               end
               if ((Cmd & CMD_RD) != '0) begin
                  rd_data_d = Rx_DATA;
               end
               if (step_q == last_step(op_rd_q)) begin
                  cmd_d     = '0;
                  rw_done_d = 1'b1;
                  ack_err_d = err_d;
                  state_d   = ST_DONE;
               end else begin
                  // 8-bit addressing has no high address byte.
                  step_adv = ((step_q == STEP_DEV) && !mode_q) ? STEP_ALO : step_q + 3'd1;
                  step_d   = step_adv;
                  dec      = step_decode(op_rd_q, dev_q, addr_q, data_q, step_adv);
                  cmd_d    = dec.cmd;
                  tx_d     = dec.tx;
                  go_d     = 1'b1;
                  state_d  = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         op_rd_q <= 1'b0;
         dev_q   <= '0;
         mode_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         Cmd     <= '0;
         Go      <= 1'b0;
         Tx_DATA <= '0;
         rd_data <= '0;
         RW_Done <= 1'b0;
         ack_err <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         op_rd_q <= op_rd_d;
         dev_q   <= dev_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
         Cmd     <= cmd_d;
         Go      <= go_d;
         Tx_DATA <= tx_d;
         rd_data <= rd_data_d;
         RW_Done <= rw_done_d;
         ack_err <= ack_err_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl with a behavioural byte-engine responder
// that logs every Go step and checks Cmd/Tx_DATA stay stable until Trans_Done.
module tb_i2c_reg_ctrl;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        wrreg_req, rdreg_req;
   logic [6:0]  dev_id;
   logic        addr_mode;
   logic [15:0] reg_addr;
   logic [7:0]  wr_data;
   logic [7:0]  rd_data;
   logic        RW_Done, ack_err, busy;
   logic [5:0]  Cmd;
   logic        Go;
   logic [7:0]  Tx_DATA;
   logic [7:0]  Rx_DATA;
   logic        Trans_Done;
   logic        ack_o;

   always #5 Clk = ~Clk;

   i2c_reg_ctrl #(.ACK_CHECK_EN(1'b1)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
      .dev_id(dev_id), .addr_mode(addr_mode), .reg_addr(reg_addr), .wr_data(wr_data),
      .rd_data(rd_data), .RW_Done(RW_Done), .ack_err(ack_err), .busy(busy),
      .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA),
      .Rx_DATA(Rx_DATA), .Trans_Done(Trans_Done), .ack_o(ack_o)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   localparam int ENG_LAT = 3;
   logic [5:0] log_cmd [0:15];
   logic [7:0] log_tx  [0:15];
   int         log_n;
   int         nack_idx;
   logic [7:0] rx_byte;
   int         eng_cnt;
   int         cur_idx;
   int         last_td_cyc;
   logic [5:0] held_cmd;
   logic [7:0] held_tx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Byte-engine responder: one Trans_Done ENG_LAT cycles after each Go.
   initial begin
      Trans_Done  = 1'b0;
      ack_o       = 1'b0;
      Rx_DATA     = 8'h00;
      eng_cnt     = 0;
      cur_idx     = 0;
      last_td_cyc = 0;
      held_cmd    = '0;
      held_tx     = '0;
      forever begin
         @(posedge Clk);
         #1;
         Trans_Done = 1'b0;
         ack_o      = 1'b0;
         if (!Rst_n) begin
            eng_cnt = 0;
         end else if (Go) begin
            chk("go_while_engine_busy", 32'(eng_cnt), 32'd0);
            if (log_n < 16) begin
               log_cmd[log_n] = Cmd;
               log_tx[log_n]  = Tx_DATA;
            end
            cur_idx  = log_n;
            log_n++;
            held_cmd = Cmd;
            held_tx  = Tx_DATA;
            eng_cnt  = ENG_LAT;
         end else if (eng_cnt > 0) begin
            chk("cmd_stable", 32'(Cmd), 32'(held_cmd));
            chk("tx_stable", 32'(Tx_DATA), 32'(held_tx));
            eng_cnt--;
            if (eng_cnt == 0) begin
               Trans_Done  = 1'b1;
               ack_o       = (cur_idx == nack_idx);
               Rx_DATA     = rx_byte;
               last_td_cyc = cyc;
            end
         end
      end
   end

   task automatic request(input logic wr, input logic rd, input logic [6:0] dev,
                          input logic mode, input logic [15:0] addr, input logic [7:0] data);
      @(negedge Clk);
      log_n     = 0;
      dev_id    = dev;
      addr_mode = mode;
      reg_addr  = addr;
      wr_data   = data;
      wrreg_req = wr;
      rdreg_req = rd;
      @(negedge Clk);
      wrreg_req = 1'b0;
      rdreg_req = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Bounded observation window; an absent RW_Done shows up as dones=0.
   task automatic run_window(input int ncyc, input logic rd_pulse, output int dones,
                             output logic err_at_done, output logic [7:0] rd_at_done,
                             output int done_cyc);
      dones       = 0;
      err_at_done = 1'b0;
      rd_at_done  = 8'h00;
      done_cyc    = -1;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge Clk);
         rdreg_req = (rd_pulse && (i == 4));
         if (RW_Done) begin
            dones++;
            err_at_done = ack_err;
            rd_at_done  = rd_data;
            done_cyc    = cyc;
            chk("busy_at_done", 32'(busy), 32'd1);
         end else begin
            chk("ack_err_low_outside_done", 32'(ack_err), 32'd0);
         end
      end
      rdreg_req = 1'b0;
      chk("idle_after_window", 32'(busy), 32'd0);
   endtask

   task automatic chk_step(input int idx, input logic [5:0] cmd, input logic [7:0] tx);
      chk($sformatf("step%0d_cmd", idx), 32'(log_cmd[idx]), 32'(cmd));
      chk($sformatf("step%0d_tx", idx), 32'(log_tx[idx]), 32'(tx));
   endtask

   int         dones;
   logic       err_d;
   logic [7:0] rd_d;
   int         done_cyc;

   initial begin
      Rst_n     = 1'b0;
      wrreg_req = 1'b0;
      rdreg_req = 1'b0;
      dev_id    = '0;
      addr_mode = 1'b0;
      reg_addr  = '0;
      wr_data   = '0;
      nack_idx  = -1;
      rx_byte   = 8'h00;
      log_n     = 0;

      repeat (3) @(negedge Clk);
      chk("rst_cmd", 32'(Cmd), 32'd0);
      chk("rst_go", 32'(Go), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rw_done", 32'(RW_Done), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("idle_tx", 32'(Tx_DATA), 32'd0);
      chk("idle_ack_err", 32'(ack_err), 32'd0);

      // 16-bit write: dev 0x3C, addr 0x3008, data 0x82
      request(1'b1, 1'b0, 7'h3C, 1'b1, 16'h3008, 8'h82);
      run_window(60, 1'b0, dones, err_d, rd_d, done_cyc);
      chk("wr16_dones", 32'(dones), 32'd1);
      chk("wr16_ack_err", 32'(err_d), 32'd0);
      chk("wr16_latency", 32'(done_cyc), 32'(last_td_cyc + 1));
      chk("wr16_nsteps", 32'(log_n), 32'd4);
      chk_step(0, 6'b000011, 8'h78);
      chk_step(1, 6'b000001, 8'h30);
      chk_step(2, 6'b000001, 8'h08);
      chk_step(3, 6'b001001, 8'h82);
      chk("idle_cmd_zero", 32'(Cmd), 32'd0);

      // 8-bit read: dev 0x21, addr 0x0A, slave returns 0x76
      rx_byte = 8'h76;
      request(1'b0, 1'b1, 7'h21, 1'b0, 16'h000A, 8'h00);
      run_window(60, 1'b0, dones, err_d, rd_d, done_cyc);
      chk("rd8_dones", 32'(dones), 32'd1);
      chk("rd8_ack_err", 32'(err_d), 32'd0);
      chk("rd8_rd_data", 32'(rd_d), 32'h76);
      chk("rd8_nsteps", 32'(log_n), 32'd4);
      chk_step(0, 6'b000011, 8'h42);
      chk_step(1, 6'b001001, 8'h0A);
      chk_step(2, 6'b000011, 8'h43);
      chk_step(3, 6'b101100, 8'h00);
      chk("rd8_rd_data_held", 32'(rd_data), 32'h76);

      // Slave NACKs the low address byte of a 16-bit write
      nack_idx = 2;
      request(1'b1, 1'b0, 7'h3C, 1'b1, 16'h1234, 8'h55);
      run_window(60, 1'b0, dones, err_d, rd_d, done_cyc);
      chk("nack_dones", 32'(dones), 32'd1);
      chk("nack_ack_err", 32'(err_d), 32'd1);
      chk("nack_nsteps", 32'(log_n), 32'd4);
      chk_step(3, 6'b001001, 8'h55);
      nack_idx = -1;

      // 16-bit read after the NACK: error must not carry over
      rx_byte = 8'hA5;
      request(1'b0, 1'b1, 7'h10, 1'b1, 16'h1234, 8'h00);
      run_window(60, 1'b0, dones, err_d, rd_d, done_cyc);
      chk("rd16_dones", 32'(dones), 32'd1);
      chk("rd16_ack_err", 32'(err_d), 32'd0);
      chk("rd16_rd_data", 32'(rd_d), 32'hA5);
      chk("rd16_nsteps", 32'(log_n), 32'd5);
      chk_step(0, 6'b000011, 8'h20);
      chk_step(1, 6'b000001, 8'h12);
      chk_step(2, 6'b001001, 8'h34);
      chk_step(3, 6'b000011, 8'h21);
      chk_step(4, 6'b101100, 8'h00);

      // Both requests together -> write wins; read pulse while busy is ignored
      rx_byte = 8'h5A;
      request(1'b1, 1'b1, 7'h3C, 1'b0, 16'h00F0, 8'h99);
      run_window(80, 1'b1, dones, err_d, rd_d, done_cyc);
      chk("both_dones", 32'(dones), 32'd1);
      chk("both_nsteps", 32'(log_n), 32'd3);
      chk_step(0, 6'b000011, 8'h78);
      chk_step(1, 6'b000001, 8'hF0);
      chk_step(2, 6'b001001, 8'h99);
      chk("both_rd_data_kept", 32'(rd_data), 32'hA5);

      // Reset during step 2 of a 16-bit write
      request(1'b1, 1'b0, 7'h3C, 1'b1, 16'h3008, 8'h82);
      for (int i = 0; i < 40; i++) begin
         if (log_n >= 3) break;
         @(negedge Clk);
      end
      chk("reached_step2", 32'(log_n >= 3), 32'd1);
      Rst_n = 1'b0;
      #1;
      chk("midrst_cmd", 32'(Cmd), 32'd0);
      chk("midrst_go", 32'(Go), 32'd0);
      chk("midrst_tx", 32'(Tx_DATA), 32'd0);
      chk("midrst_rd_data", 32'(rd_data), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rw_done", 32'(RW_Done), 32'd0);
      chk("midrst_ack_err", 32'(ack_err), 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      request(1'b1, 1'b0, 7'h3C, 1'b1, 16'h3008, 8'h82);
      run_window(60, 1'b0, dones, err_d, rd_d, done_cyc);
      chk("postrst_dones", 32'(dones), 32'd1);
      chk("postrst_ack_err", 32'(err_d), 32'd0);
      chk("postrst_nsteps", 32'(log_n), 32'd4);
      chk_step(0, 6'b000011, 8'h78);
      chk_step(3, 6'b001001, 8'h82);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
